// File: rtl/neuron_sequencer.sv
// neuron_sequencer: control stage in front of the 4-input neural unit.
// Streams four weight bytes into the unit's weight bank, fires sumTrigger after
// a settle delay on start, then captures layerOut and hands it downstream.
// Optional feature: define NEURON_SEQ_WATCHDOG_EN to build the layerDone
// watchdog (drives the sticky err flag); otherwise err is tied low.
module neuron_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  w_data,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic        start,
    output logic [7:0]  weight,
    output logic [1:0]  address,
    output logic        write,
    output logic        sumTrigger,
    input  logic [31:0] layerOut,
    input  logic        layerDone,
    output logic [31:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        err
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gSettleRangeCheck
        $error("SETTLE_CYCLES must be in 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : gTimeoutRangeCheck
        $error("TIMEOUT must be in 1..255");
    end

    typedef enum logic [2:0] {
        StLoad,
        StArmed,
        StSettle,
        StFire,
        StWaitDone,
        StHold
    } stateE;

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

    stateE       stateQ, stateD;
    logic [1:0]  wcntQ, wcntD;
    logic [3:0]  settleQ, settleD;
    logic [7:0]  weightQ, weightD;
    logic [1:0]  addressQ, addressD;
    logic        writeQ, writeD;
    logic [31:0] resultQ, resultD;
    logic        wAccept;

`ifdef NEURON_SEQ_WATCHDOG_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    logic [7:0]  wdogQ, wdogD;
    logic        errQ, errD;
`endif

    // Handshake and state-decoded outputs; w_ready is forced low while reset is held.
    always_comb begin
        w_ready      = !reset && ((stateQ == StLoad) || ((stateQ == StArmed) && !start));
        wAccept      = w_valid && w_ready;
        sumTrigger   = (stateQ == StFire);
        busy         = (stateQ == StSettle) || (stateQ == StFire) || (stateQ == StWaitDone);
        result_valid = (stateQ == StHold);
        weight       = weightQ;
        address      = addressQ;
        write        = writeQ;
        result       = resultQ;
`ifdef NEURON_SEQ_WATCHDOG_EN
        err          = errQ;
`else
        err          = 1'b0;
`endif
    end

    // Next-state logic: weight streaming, settle countdown, result capture.
    always_comb begin
        stateD   = stateQ;
        wcntD    = wcntQ;
        settleD  = settleQ;
        weightD  = weightQ;
        addressD = addressQ;
        writeD   = 1'b0;
        resultD  = resultQ;
`ifdef NEURON_SEQ_WATCHDOG_EN
        wdogD    = wdogQ;
        errD     = errQ;
`endif
        unique case (stateQ)
            StLoad: begin
                if (wAccept) begin
                    weightD  = w_data;
                    addressD = wcntQ;
                    writeD   = 1'b1;
                    wcntD    = wcntQ + 2'd1;
                    if (wcntQ == 2'd3) begin
                        stateD = StArmed;
                    end
                end
            end
            StArmed: begin
                if (start) begin
                    settleD = SettleInit;
`ifdef NEURON_SEQ_WATCHDOG_EN
                    errD    = 1'b0;
`endif
                    stateD  = StSettle;
                end else if (wAccept) begin
                    // wcnt wrapped to 0 on the last load, so a reload starts at address 0.
                    weightD  = w_data;
                    addressD = wcntQ;
                    writeD   = 1'b1;
                    wcntD    = wcntQ + 2'd1;
                    stateD   = StLoad;
                end
            end
            StSettle: begin
                if (settleQ <= 4'd1) begin
                    stateD = StFire;
                end else begin
                    settleD = settleQ - 4'd1;
                end
            end
            StFire: begin
                stateD = StWaitDone;
`ifdef NEURON_SEQ_WATCHDOG_EN
                wdogD  = 8'd0;
`endif
            end
            StWaitDone: begin
                if (layerDone) begin
                    resultD = layerOut;
                    stateD  = StHold;
`ifdef NEURON_SEQ_WATCHDOG_EN
                end else if (wdogQ == TimeoutLast) begin
                    errD   = 1'b1;
                    stateD = StArmed;
                end else begin
                    wdogD = wdogQ + 8'd1;
`endif
                end
            end
            StHold: begin
                if (result_ready) begin
                    stateD = StArmed;
                end
            end
            default: stateD = StLoad;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StLoad;
            wcntQ    <= 2'd0;
            settleQ  <= 4'd0;
            weightQ  <= 8'd0;
            addressQ <= 2'd0;
            writeQ   <= 1'b0;
            resultQ  <= 32'd0;
`ifdef NEURON_SEQ_WATCHDOG_EN
            wdogQ    <= 8'd0;
            errQ     <= 1'b0;
`endif
        end else begin
            stateQ   <= stateD;
            wcntQ    <= wcntD;
            settleQ  <= settleD;
            weightQ  <= weightD;
            addressQ <= addressD;
            writeQ   <= writeD;
            resultQ  <= resultD;
`ifdef NEURON_SEQ_WATCHDOG_EN
            wdogQ    <= wdogD;
            errQ     <= errD;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer: stimulus tasks queue expected writes,
// trigger cycles and results; a negedge monitor pops and compares them.
module tb_neuron_sequencer;

    localparam int unsigned S  = 2;
    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  w_data = 8'd0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic        start = 1'b0;
    logic [7:0]  weight;
    logic [1:0]  address;
    logic        write;
    logic        sumTrigger;
    logic [31:0] layerOut = 32'd0;
    logic        layerDone = 1'b0;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        err;

    neuron_sequencer #(
        .SETTLE_CYCLES(S),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .start       (start),
        .weight      (weight),
        .address     (address),
        .write       (write),
        .sumTrigger  (sumTrigger),
        .layerOut    (layerOut),
        .layerDone   (layerDone),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Edge counter: a negedge seeing cyc == j lies just after rising edge j.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         at;
        logic [1:0] a;
        logic [7:0] d;
    } wrT;

    wrT          expWr[$];
    int          expTrig[$];
    logic [31:0] expRes[$];

    // Reference model: next weight address in the bank.
    int mWcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    always @(negedge clk) begin
        wrT e;
        if (!reset) begin
            if (write) begin
                if (expWr.size() == 0) begin
                    check("write without accept", write, 0);
                end else begin
                    e = expWr.pop_front();
                    check("write cycle", cyc, e.at);
                    check("write address", address, e.a);
                    check("write weight", weight, e.d);
                end
            end
            if (sumTrigger) begin
                if (expTrig.size() == 0) check("sumTrigger without start", sumTrigger, 0);
                else check("sumTrigger cycle", cyc, expTrig.pop_front());
            end
            if (result_valid && result_ready) begin
                if (expRes.size() == 0) check("result without layerDone", result_valid, 0);
                else check("result value", result, expRes.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        w_data  = b;
        w_valid = 1'b1;
        @(negedge clk);
        check("w_ready for byte", w_ready, 1);
        expWr.push_back('{cyc + 1, 2'(mWcnt), b});
        mWcnt = (mWcnt + 1) % 4;
        tick();
        w_valid = 1'b0;
        w_data  = 8'($urandom);
    endtask

    // Byte i of word goes to address i; gaps also poke start while in LOAD.
    task automatic loadAll(input logic [31:0] word, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    start  = (mWcnt != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    w_data = 8'($urandom);
                    tick();
                end
                start = 1'b0;
            end
            sendByte(word[8*i +: 8]);
        end
    endtask

    task automatic startEval(input bit withByte);
        start = 1'b1;
        if (withByte) begin
            w_valid = 1'b1;
            w_data  = 8'($urandom);
        end
        @(negedge clk);
        check("w_ready while start", w_ready, 0);
        expTrig.push_back(cyc + 1 + int'(S));
        tick();
        start   = 1'b0;
        w_valid = 1'b0;
    endtask

    task automatic waitTrig(output int at);
        bit found = 1'b0;
        at = -1;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (sumTrigger) begin
                found = 1'b1;
                at    = cyc;
                check("busy in FIRE", busy, 1);
            end
        end
        if (!found) check("sumTrigger seen", 0, 1);
        tick();
    endtask

    task automatic finishEval(input logic [31:0] val, input int lat, input int bp);
        repeat (lat) begin
            layerOut = $urandom;
            tick();
        end
        layerOut  = val;
        layerDone = 1'b1;
        expRes.push_back(val);
        tick();
        layerDone = 1'b0;
        @(negedge clk);
        check("result_valid after layerDone", result_valid, 1);
        check("busy in HOLD", busy, 0);
        check("result after layerDone", result, val);
        tick();
        // Backpressure: junk on layerDone/layerOut/start must not disturb the held result.
        repeat (bp) begin
            layerDone = 1'($urandom_range(0, 1));
            layerOut  = $urandom;
            start     = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("result held", result, val);
            check("result_valid held", result_valid, 1);
            tick();
        end
        layerDone    = 1'b0;
        start        = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        @(negedge clk);
        check("result_valid cleared", result_valid, 0);
        check("w_ready back in ARMED", w_ready, 1);
        tick();
    endtask

    task automatic checkResetValues();
        check("reset w_ready", w_ready, 0);
        check("reset weight", weight, 0);
        check("reset address", address, 0);
        check("reset write", write, 0);
        check("reset sumTrigger", sumTrigger, 0);
        check("reset result", result, 0);
        check("reset result_valid", result_valid, 0);
        check("reset busy", busy, 0);
        check("reset err", err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got hang, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        logic [31:0] v;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        checkResetValues();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("w_ready after reset release", w_ready, 1);
        tick();

        // Back-to-back load, start in the first ARMED cycle
        loadAll(32'h4433_2211, 1'b0);
        startEval(1'b0);
        waitTrig(t);
        finishEval(32'h0000_1234, 1, 10);

        // Reuse weights with no reload
        startEval(1'b0);
        waitTrig(t);
        finishEval($urandom, 0, 0);

        // Start/weight collision: start wins, no write
        startEval(1'b1);
        waitTrig(t);
        finishEval($urandom, 3, 2);

        // Reset during WAIT_DONE
        startEval(1'b0);
        waitTrig(t);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        checkResetValues();
        tick();
        reset = 1'b0;
        mWcnt = 0;
        loadAll($urandom, 1'b1);
        startEval(1'b0);
        waitTrig(t);
        finishEval($urandom, 2, 1);

`ifdef NEURON_SEQ_WATCHDOG_EN
        // Watchdog: no layerDone, err after TO cycles of WAIT_DONE
        begin
            bit seen = 1'b0;
            startEval(1'b0);
            waitTrig(t);
            for (int n = 0; n < 400 && !seen; n++) begin
                @(negedge clk);
                if (err) begin
                    seen = 1'b1;
                    check("watchdog err cycle", cyc, t + int'(TO) + 1);
                    check("watchdog result_valid", result_valid, 0);
                    check("watchdog back in ARMED", w_ready, 1);
                    check("watchdog busy", busy, 0);
                end
            end
            if (!seen) check("watchdog err raised", err, 1);
            tick();
            startEval(1'b0);
            @(negedge clk);
            check("err cleared by start", err, 0);
            waitTrig(t);
            finishEval($urandom, 1, 1);
        end
`endif

        // Randomized traffic
        for (int it = 0; it < 15; it++) begin
            if ($urandom_range(0, 1) == 1) loadAll($urandom, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            startEval(1'($urandom_range(0, 1)));
            waitTrig(t);
            v = $urandom;
            finishEval(v, $urandom_range(0, 6), $urandom_range(0, 4));
`ifndef NEURON_SEQ_WATCHDOG_EN
            check("err tied low", err, 0);
`endif
        end

        repeat (4) tick();
        check("pending writes", expWr.size(), 0);
        check("pending triggers", expTrig.size(), 0);
        check("pending results", expRes.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
